bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Parametrised multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It is the successor of the free-running 8-bit converter. Additions over that block:
- generic input width and digit count
- optional two's-complement input
- start/ready/valid handshake
- overflow detection when the value exceeds the digit capacity

It sits between binary datapaths (counters, PWM duty registers) and the 7-segment display driver.

Parameters:
BIN_W, 8, input width in bits; legal range 2..32.
DIGITS, 3, number of BCD output digits; legal range 1..10.
SIGNED, 0, 0 = unsigned input; 1 = two's-complement input, magnitude converted and sign reported on neg.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  conversion request; accepted only when ready=1.
bin  in  BIN_W  binary operand; sampled on the accepting edge only.
ready  out  1  high in IDLE; converter can accept start.
valid  out  1  one-cycle pulse; bcd/neg/ovf updated this cycle.
bcd  out  4*DIGITS  result; digit k at bits [4k+3:4k], k=0 is the units digit; held until the next valid.
neg  out  1  sign of the last result (always 0 when SIGNED=0).
ovf  out  1  last result exceeded 10^DIGITS-1; held with bcd.

Behaviour:
- Reset (async, any state):
  - state=IDLE; ready=1; valid=0; bcd=0; neg=0; ovf=0.
  - Shift counter, scratch BCD register and operand register cleared.
  - Reset during SHIFT aborts the conversion with no valid pulse.
- FSM states:
  - IDLE: ready=1. On start=1, latch the operand and enter SHIFT.
    - Operand = bin when SIGNED=0.
    - When SIGNED=1: operand = |bin| as BIN_W-bit unsigned (e.g. -128 -> 128 for BIN_W=8); sign latched from bin[BIN_W-1].
    - Scratch BCD, pending overflow and counter are cleared; counter loads BIN_W.
  - SHIFT: ready=0. Each cycle:
    - Every scratch digit >= 5 has 3 added (4-bit, no carry between digits).
    - Scratch is shifted left by 1, with the operand MSB entering bit 0.
    - Operand shifts left; counter decrements.
    - If the bit shifted out of scratch bit 4*DIGITS-1 is 1, the sticky pending overflow is set.
    - When the counter reaches 0 after the shift, go to IDLE. On that same edge, register bcd, neg and ovf, and assert valid for exactly the following cycle.
- Overflow: when pending overflow is set at completion, bcd is forced to all 9s (saturate) and ovf=1. Otherwise bcd is the exact conversion and ovf=0.
- Latency and throughput:
  - Start accepted at edge E0; valid is high in the cycle after edge E_BIN_W (BIN_W cycles of latency).
  - ready returns high in the same cycle as valid. A start in that cycle is accepted, giving one conversion per BIN_W+1 cycles.
- Start handling:
  - start while ready=0 is ignored; bin changes during SHIFT have no effect.
  - start held high continuously produces back-to-back conversions.
- neg: when SIGNED=1 and the input is zero, neg=0. neg and ovf change only on valid edges.
- Counter width: $clog2(BIN_W+1). Scratch width: 4*DIGITS. No combinational path from inputs to outputs.

Test Plan:
1. Defaults, bin=8'd255, start pulse -> valid exactly 8 cycles after the accept edge; bcd=12'h255, ovf=0, neg=0; ready high in the valid cycle.
2. Defaults, bin=0 then bin=8'd9 back-to-back with start held high -> two valid pulses 9 cycles apart; bcd=12'h000 then 12'h009.
3. SIGNED=1, bin=8'h80 -> neg=1, bcd=12'h128. Then bin=8'hF6 -> neg=1, bcd=12'h010. Then bin=8'h00 -> neg=0, bcd=12'h000.
4. DIGITS=2, bin=8'd100 -> ovf=1, bcd=8'h99. Follow with bin=8'd99 -> ovf=0, bcd=8'h99.
5. Defaults, start with bin=8'd200, then a start pulse with bin=8'd7 at cycle 3 -> second start ignored; a single valid with bcd=12'h200.
6. Defaults, bin=8'd123; assert rst at cycle 4 of SHIFT -> no valid pulse; bcd=0, ready=1 immediately. After release, bin=8'd45 -> bcd=12'h045 after 8 cycles.
7. BIN_W=16, DIGITS=5, bin=16'hFFFF -> bcd=20'h65535 after 16 cycles, ovf=0.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq : multi-cycle binary-to-BCD converter (shift-and-add-3), 1 bit/clk
// Rev 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  ready,
   output logic                  valid,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg,
   output logic                  ovf
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [BIN_W-1:0] opnd;
   logic [SW-1:0]    scratch;
   logic             pend;
   logic             sign_q;

   logic [BIN_W-1:0] mag;
   logic             sign_in;
   logic [SW-1:0]    adj;
   logic [SW-1:0]    shifted;
   logic             pend_nxt;
   logic             last;

   generate
      if (SIGNED != 0) begin : g_signed
         assign sign_in = bin[BIN_W-1];
         // Most negative value maps to its unsigned magnitude (e.g. -128 -> 128).
         assign mag     = sign_in ? ((~bin) + {{(BIN_W-1){1'b0}}, 1'b1}) : bin;
      end else begin : g_unsigned
         assign sign_in = 1'b0;
         assign mag     = bin;
      end
   endgenerate

   genvar k;
   generate
      for (k = 0; k < DIGITS; k++) begin : g_digit
         assign adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5) ? (scratch[4*k +: 4] + 4'd3)
                                                           : scratch[4*k +: 4];
      end
   endgenerate

   assign shifted  = {adj[SW-2:0], opnd[BIN_W-1]};
   assign pend_nxt = pend | adj[SW-1];
   assign last     = (cnt == {{(CW-1){1'b0}}, 1'b1});
   assign ready    = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         opnd    <= '0;
         scratch <= '0;
         pend    <= 1'b0;
         sign_q  <= 1'b0;
         valid   <= 1'b0;
         bcd     <= '0;
         neg     <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opnd    <= mag;
                  sign_q  <= sign_in;
                  scratch <= '0;
                  pend    <= 1'b0;
                  cnt     <= CW'(BIN_W);
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= shifted;
               opnd    <= opnd << 1;
               cnt     <= cnt - 1'b1;
               pend    <= pend_nxt;
               if (last) begin
                  state <= IDLE;
                  valid <= 1'b1;
                  neg   <= sign_q;
                  // Saturate to all nines once any digit carry fell off the top.
                  if (pend_nxt) begin
                     bcd <= {DIGITS{4'h9}};
                     ovf <= 1'b1;
                  end else begin
                     bcd <= shifted;
                     ovf <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
